// File: rtl/iccm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iccm_arb_pkg
// Description : Shared types and sizes for the ICCM port arbiter.
//               - req_e   : identifies a requester (also used as the response
//                           routing tag)
//               - ICCM_*  : default ICCM geometry
// Revision    : 1.0 - initial release
// ============================================================================
package iccm_arb_pkg;

    localparam int ICCM_ADDR_W = 12;
    localparam int ICCM_DATA_W = 32;
    localparam int ICCM_BE_W   = 4;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_LDR  = 2'd1,
        REQ_IF   = 2'd2,
        REQ_BUS  = 2'd3
    } req_e;

endpackage : iccm_arb_pkg
`default_nettype wire

// File: rtl/iccm_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : iccm_rr_arb2
// Description : Two-way round-robin arbiter with enable.
//               Ports:
//                 clk_i  - clock
//                 rst_i  - synchronous active-high reset (pointer -> req 0)
//                 i_en   - arbitration enable; no grants while low
//                 i_req  - request vector, bit 0 = fetch, bit 1 = bus
//                 o_gnt  - one-hot grant vector (same cycle as request)
//               The pointer names the requester that wins a tie. After any
//               grant it moves to the requester that was not granted, so a
//               lone request does not steal the next tie from the other side.
// Revision    : 1.0 - initial release
// ============================================================================
module iccm_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic       r_ptr;   // 0: fetch wins a tie, 1: bus wins a tie
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= 1'b0;
        end else if (w_gnt[0]) begin
            r_ptr <= 1'b1;
        end else if (w_gnt[1]) begin
            r_ptr <= 1'b0;
        end
    end

    assign o_gnt = w_gnt;

endmodule : iccm_rr_arb2
`default_nettype wire

// File: rtl/iccm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iccm_port_arbiter
// Description : Shares the single-port ICCM SRAM between the UART program
//               loader (write-only, highest priority), the core fetch port
//               and the system-bus/debug port, and returns the 1-cycle read
//               data to the requester that issued the read.
//               Ports:
//                 clk_i, rst_i          - clock, synchronous active-high reset
//                 prog_i                - programming mode, blocks fetch/bus
//                 ldr_*                 - loader write port (pulse strobe)
//                 if_*                  - fetch read port (req/gnt/rvalid)
//                 bus_*                 - bus read/write port (req/gnt/rvalid)
//                 mem_*                 - SRAM macro pins (csb/web active-low)
// Revision    : 1.0 - initial release
// ============================================================================
module iccm_port_arbiter
    import iccm_arb_pkg::*;
#(
    parameter int ADDR_W = ICCM_ADDR_W,
    parameter int DATA_W = ICCM_DATA_W,
    parameter int BE_W   = ICCM_BE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prog_i,
    input  logic              ldr_we_i,
    input  logic [ADDR_W-1:0] ldr_addr_i,
    input  logic [DATA_W-1:0] ldr_wdata_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              bus_req_i,
    input  logic              bus_we_i,
    input  logic [BE_W-1:0]   bus_be_i,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic [DATA_W-1:0] bus_wdata_i,
    output logic              bus_gnt_o,
    output logic              bus_rvalid_o,
    output logic [DATA_W-1:0] bus_rdata_o,
    output logic              mem_csb_o,
    output logic              mem_web_o,
    output logic [BE_W-1:0]   mem_wmask_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    logic       w_ldr_act;
    logic       w_arb_en;
    logic [1:0] w_gnt;
    req_e       r_rsp_sel;
    logic       r_rsp_we;

    // Reset suppresses every access, including the loader.
    assign w_ldr_act = ldr_we_i & ~rst_i;
    // Loader cycles disable the arbiter, so they leave the pointer untouched.
    assign w_arb_en  = ~rst_i & ~ldr_we_i & ~prog_i;

    iccm_rr_arb2 u_rr_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_en  (w_arb_en),
        .i_req ({bus_req_i, if_req_i}),
        .o_gnt (w_gnt)
    );

    assign if_gnt_o  = w_gnt[0];
    assign bus_gnt_o = w_gnt[1];

    // SRAM pin mux; idle and read cycles drive unused fields to zero.
    always_comb begin
        mem_csb_o   = 1'b1;
        mem_web_o   = 1'b1;
        mem_wmask_o = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_ldr_act) begin
            mem_csb_o   = 1'b0;
            mem_web_o   = 1'b0;
            mem_wmask_o = '1;
            mem_addr_o  = ldr_addr_i;
            mem_wdata_o = ldr_wdata_i;
        end else if (w_gnt[0]) begin
            mem_csb_o   = 1'b0;
            mem_addr_o  = if_addr_i;
        end else if (w_gnt[1]) begin
            mem_csb_o   = 1'b0;
            mem_addr_o  = bus_addr_i;
            if (bus_we_i) begin
                mem_web_o   = 1'b0;
                mem_wmask_o = bus_be_i;
                mem_wdata_o = bus_wdata_i;
            end
        end
    end

    // Response tag: which port owns the SRAM output in the next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_sel <= REQ_NONE;
            r_rsp_we  <= 1'b0;
        end else begin
            r_rsp_we <= bus_we_i;
            if (w_gnt[0]) begin
                r_rsp_sel <= REQ_IF;
            end else if (w_gnt[1]) begin
                r_rsp_sel <= REQ_BUS;
            end else begin
                r_rsp_sel <= REQ_NONE;
            end
        end
    end

    assign if_rvalid_o  = (r_rsp_sel == REQ_IF);
    assign bus_rvalid_o = (r_rsp_sel == REQ_BUS);
    assign if_rdata_o   = if_rvalid_o ? mem_rdata_i : '0;
    // A bus write is acknowledged with zero data.
    assign bus_rdata_o  = (bus_rvalid_o && !r_rsp_we) ? mem_rdata_i : '0;

endmodule : iccm_port_arbiter
`default_nettype wire

// File: tb/tb_iccm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iccm_port_arbiter
// Description : Self-checking bench for iccm_port_arbiter. A behavioural SRAM
//               sits on the mem_* pins; a reference model (priority rules,
//               tie-break preference, pending-response slot and a shadow copy
//               of memory contents) predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iccm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_i, prog_i, ldr_we_i, if_req_i, bus_req_i, bus_we_i;
    logic [11:0] ldr_addr_i, if_addr_i, bus_addr_i;
    logic [31:0] ldr_wdata_i, bus_wdata_i;
    logic [3:0]  bus_be_i;
    logic        if_gnt_o, if_rvalid_o, bus_gnt_o, bus_rvalid_o;
    logic [31:0] if_rdata_o, bus_rdata_o;
    logic        mem_csb_o, mem_web_o;
    logic [3:0]  mem_wmask_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iccm_port_arbiter dut (
        .clk_i(clk), .rst_i(rst_i), .prog_i(prog_i),
        .ldr_we_i(ldr_we_i), .ldr_addr_i(ldr_addr_i), .ldr_wdata_i(ldr_wdata_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_be_i(bus_be_i),
        .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i), .bus_gnt_o(bus_gnt_o),
        .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o),
        .mem_csb_o(mem_csb_o), .mem_web_o(mem_web_o), .mem_wmask_o(mem_wmask_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // Behavioural single-port SRAM, 1-cycle read latency.
    bit [31:0] sram [0:4095];
    always @(posedge clk) begin
        if (!mem_csb_o) begin
            if (!mem_web_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    // ---------------- reference model ----------------
    // m_win: 0 none, 1 loader, 2 fetch, 3 bus. m_pref: 0 fetch / 1 bus wins a tie.
    bit [31:0] ref_mem [0:4095];
    int          m_pref = 0;
    int          m_pend = 0;
    int          m_win  = 0;
    logic [31:0] m_pdata = 32'h0;
    logic        e_if_gnt, e_bus_gnt, e_csb, e_web, e_if_rv, e_bus_rv;
    logic [3:0]  e_wmask;
    logic [11:0] e_addr;
    logic [31:0] e_wdata, e_if_rd, e_bus_rd;

    task automatic model_eval();
        e_if_rv  = (m_pend == 2);
        e_bus_rv = (m_pend == 3);
        e_if_rd  = e_if_rv  ? m_pdata : 32'h0;
        e_bus_rd = e_bus_rv ? m_pdata : 32'h0;
        m_win = 0;
        if (rst_i)          m_win = 0;
        else if (ldr_we_i)  m_win = 1;
        else if (!prog_i) begin
            if (if_req_i && bus_req_i) m_win = (m_pref == 0) ? 2 : 3;
            else if (if_req_i)         m_win = 2;
            else if (bus_req_i)        m_win = 3;
        end
        e_if_gnt = (m_win == 2);
        e_bus_gnt = (m_win == 3);
        e_csb = 1'b1; e_web = 1'b1; e_wmask = 4'h0; e_addr = 12'h0; e_wdata = 32'h0;
        case (m_win)
            1: begin e_csb = 0; e_web = 0; e_wmask = 4'hF; e_addr = ldr_addr_i; e_wdata = ldr_wdata_i; end
            2: begin e_csb = 0; e_addr = if_addr_i; end
            3: begin
                e_csb = 0; e_addr = bus_addr_i;
                if (bus_we_i) begin e_web = 0; e_wmask = bus_be_i; e_wdata = bus_wdata_i; end
            end
            default: ;
        endcase
    endtask

    task automatic model_commit();
        if (rst_i) begin
            m_pend = 0; m_pref = 0;
        end else begin
            case (m_win)
                1: ref_mem[ldr_addr_i] = ldr_wdata_i;
                2: begin m_pdata = ref_mem[if_addr_i]; m_pref = 1; end
                3: begin
                    if (bus_we_i) begin
                        for (int b = 0; b < 4; b++)
                            if (bus_be_i[b]) ref_mem[bus_addr_i][b*8 +: 8] = bus_wdata_i[b*8 +: 8];
                        m_pdata = 32'h0;
                    end else begin
                        m_pdata = ref_mem[bus_addr_i];
                    end
                    m_pref = 0;
                end
                default: ;
            endcase
            m_pend = (m_win >= 2) ? m_win : 0;
        end
    endtask

    // look: move to the sampling point and predict; tick: retire the cycle.
    task automatic look();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_i = 0; prog_i = 0; ldr_we_i = 0; if_req_i = 0; bus_req_i = 0; bus_we_i = 0;
    endtask

    function automatic logic [11:0] rand_addr();
        if ($urandom % 8 == 0) return 12'hFFF - 12'($urandom % 4);
        return 12'($urandom % 64);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        idle(); rst_i = 1; if_req_i = 1; if_addr_i = 12'h010;
        bus_addr_i = 12'h002; bus_be_i = 4'h0; bus_wdata_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            look(); n_cmp++;
            if ({if_gnt_o, bus_gnt_o, mem_csb_o, mem_web_o, if_rvalid_o, bus_rvalid_o} !== 6'b001100) begin
                n_bad++; $display("FAIL reset_ctrl: got gnt=%b%b csb=%b web=%b rv=%b%b expected 001100",
                    if_gnt_o, bus_gnt_o, mem_csb_o, mem_web_o, if_rvalid_o, bus_rvalid_o);
            end
            n_cmp++;
            if ({if_rdata_o, bus_rdata_o} !== 64'h0) begin
                n_bad++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata_o, bus_rdata_o);
            end
            tick();
        end
        rst_i = 0;
        look(); n_cmp++;
        if ({if_gnt_o, bus_gnt_o} !== 2'b10) begin
            n_bad++; $display("FAIL reset_release_gnt: got %b%b expected 10", if_gnt_o, bus_gnt_o);
        end
        tick();
        bus_req_i = 1;   // pointer must now favour the bus
        look(); n_cmp++;
        if ({if_gnt_o, bus_gnt_o, if_rvalid_o} !== 3'b011) begin
            n_bad++; $display("FAIL reset_ptr_moves: got gnt=%b%b if_rv=%b expected 01 1", if_gnt_o, bus_gnt_o, if_rvalid_o);
        end
        tick();
        idle();
        look(); tick();
    endtask

    task automatic test_loader_fill();
        idle();
        for (int a = 0; a < 65; a++) begin
            ldr_we_i = 1; ldr_addr_i = (a == 64) ? 12'hFFF : 12'(a); ldr_wdata_i = $urandom;
            look(); n_cmp++;
            if ({mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_wdata_o} !== {2'b00, 4'hF, ldr_addr_i, ldr_wdata_i}) begin
                n_bad++; $display("FAIL loader_write: got csb=%b web=%b m=%h a=%h d=%h expected 0 0 f %h %h",
                    mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_wdata_o, ldr_addr_i, ldr_wdata_i);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_fetch_read();
        idle(); ldr_we_i = 1; ldr_addr_i = 12'h010; ldr_wdata_i = 32'h00000013;
        look(); tick();
        idle(); if_req_i = 1; if_addr_i = 12'h010;
        look(); n_cmp++;
        if ({if_gnt_o, mem_csb_o, mem_web_o, mem_addr_o} !== {3'b101, 12'h010}) begin
            n_bad++; $display("FAIL fetch_req: got gnt=%b csb=%b web=%b a=%h expected 1 0 1 010",
                if_gnt_o, mem_csb_o, mem_web_o, mem_addr_o);
        end
        tick();
        if_req_i = 0;
        look(); n_cmp++;
        if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h00000013}) begin
            n_bad++; $display("FAIL fetch_rsp: got rv=%b d=%h expected 1 00000013", if_rvalid_o, if_rdata_o);
        end
        tick();
    endtask

    task automatic test_contention();
        idle(); rst_i = 1; look(); tick();
        idle(); if_req_i = 1; if_addr_i = 12'h001; bus_req_i = 1; bus_we_i = 0; bus_addr_i = 12'h002;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin if_req_i = 0; bus_req_i = 0; end
            look();
            if (i < 4) begin
                n_cmp++;
                if ({if_gnt_o, bus_gnt_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_bad++; $display("FAIL contention_gnt%0d: got %b%b expected %b", i, if_gnt_o, bus_gnt_o,
                        (i % 2 == 0) ? 2'b10 : 2'b01);
                end
            end
            if (i > 0) begin
                n_cmp++;
                if ({if_rvalid_o, bus_rvalid_o, if_rdata_o, bus_rdata_o} !== {((i % 2) == 1), ((i % 2) == 0), e_if_rd, e_bus_rd}) begin
                    n_bad++; $display("FAIL contention_rsp%0d: got rv=%b%b d=%h/%h expected rv=%b%b d=%h/%h", i,
                        if_rvalid_o, bus_rvalid_o, if_rdata_o, bus_rdata_o, e_if_rv, e_bus_rv, e_if_rd, e_bus_rd);
                end
            end
            tick();
        end
    endtask

    task automatic test_loader_override();
        idle(); if_req_i = 1; if_addr_i = 12'h005;
        ldr_we_i = 1; ldr_addr_i = 12'h005; ldr_wdata_i = 32'hDEADBEEF;
        look(); n_cmp++;
        if ({if_gnt_o, bus_gnt_o, mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_wdata_o} !==
            {4'b0000, 4'hF, 12'h005, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL loader_override: got gnt=%b csb=%b web=%b m=%h a=%h d=%h expected 0 0 0 f 005 deadbeef",
                if_gnt_o, mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        ldr_we_i = 0;
        look(); n_cmp++;
        if ({if_gnt_o, mem_addr_o} !== {1'b1, 12'h005}) begin
            n_bad++; $display("FAIL loader_then_fetch: got gnt=%b a=%h expected 1 005", if_gnt_o, mem_addr_o);
        end
        tick();
        if_req_i = 0;
        look(); n_cmp++;
        if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL loader_readback: got rv=%b d=%h expected 1 deadbeef", if_rvalid_o, if_rdata_o);
        end
        tick();
    endtask

    task automatic test_bus_byte_write();
        logic [31:0] old_word;
        old_word = ref_mem[12'h020];
        idle(); bus_req_i = 1; bus_we_i = 1; bus_be_i = 4'b0011; bus_addr_i = 12'h020; bus_wdata_i = 32'h1234ABCD;
        look(); n_cmp++;
        if ({bus_gnt_o, mem_web_o, mem_wmask_o, mem_wdata_o} !== {2'b10, 4'b0011, 32'h1234ABCD}) begin
            n_bad++; $display("FAIL bus_write: got gnt=%b web=%b m=%b d=%h expected 1 0 0011 1234abcd",
                bus_gnt_o, mem_web_o, mem_wmask_o, mem_wdata_o);
        end
        tick();
        bus_we_i = 0; bus_be_i = 4'h0;   // follow with a read of the same word
        look(); n_cmp++;
        if ({bus_rvalid_o, bus_rdata_o} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL bus_write_ack: got rv=%b d=%h expected 1 00000000", bus_rvalid_o, bus_rdata_o);
        end
        n_cmp++;
        if ({bus_gnt_o, mem_web_o, mem_wmask_o} !== {2'b11, 4'h0}) begin
            n_bad++; $display("FAIL bus_read_req: got gnt=%b web=%b m=%b expected 1 1 0000", bus_gnt_o, mem_web_o, mem_wmask_o);
        end
        tick();
        bus_req_i = 0;
        look(); n_cmp++;
        if ({bus_rvalid_o, bus_rdata_o} !== {1'b1, old_word[31:16], 16'hABCD}) begin
            n_bad++; $display("FAIL bus_byte_merge: got rv=%b d=%h expected 1 %h", bus_rvalid_o, bus_rdata_o,
                {old_word[31:16], 16'hABCD});
        end
        tick();
    endtask

    task automatic test_prog_mode();
        idle(); rst_i = 1; look(); tick();
        idle(); bus_req_i = 1; bus_we_i = 0; bus_addr_i = 12'h003;   // leaves a bus response pending
        look(); tick();
        prog_i = 1; if_req_i = 1; if_addr_i = 12'h031;
        for (int i = 0; i < 5; i++) begin
            ldr_we_i = (i % 2 == 1); ldr_addr_i = 12'h030 + 12'(i); ldr_wdata_i = $urandom;
            look();
            if (i == 0) begin
                n_cmp++;
                if ({bus_rvalid_o, bus_rdata_o} !== {1'b1, e_bus_rd}) begin
                    n_bad++; $display("FAIL prog_pending_rsp: got rv=%b d=%h expected 1 %h", bus_rvalid_o, bus_rdata_o, e_bus_rd);
                end
            end
            n_cmp++;
            if ({if_gnt_o, bus_gnt_o, mem_csb_o, mem_web_o} !== {2'b00, ~ldr_we_i, ~ldr_we_i}) begin
                n_bad++; $display("FAIL prog_block%0d: got gnt=%b%b csb=%b web=%b expected 00 %b %b", i,
                    if_gnt_o, bus_gnt_o, mem_csb_o, mem_web_o, ~ldr_we_i, ~ldr_we_i);
            end
            tick();
        end
        prog_i = 0; ldr_we_i = 0;
        look(); n_cmp++;
        if ({if_gnt_o, bus_gnt_o} !== 2'b10) begin
            n_bad++; $display("FAIL prog_exit_gnt: got %b%b expected 10", if_gnt_o, bus_gnt_o);
        end
        tick();
        idle(); look(); tick();
    endtask

    task automatic test_reset_mid_response();
        idle(); if_req_i = 1; if_addr_i = 12'h007;
        look(); tick();
        if_req_i = 0; rst_i = 1;
        look(); tick();
        rst_i = 0;
        look(); n_cmp++;
        if ({if_rvalid_o, bus_rvalid_o, if_rdata_o} !== {2'b00, 32'h0}) begin
            n_bad++; $display("FAIL reset_drops_rsp: got rv=%b%b d=%h expected 00 0", if_rvalid_o, bus_rvalid_o, if_rdata_o);
        end
        tick();
    endtask

    task automatic test_random();
        bit if_hold = 0;
        bit bus_hold = 0;
        idle(); rst_i = 1; look(); tick();
        for (int c = 0; c < 800; c++) begin
            rst_i = ($urandom % 64 == 0);
            if ($urandom % 16 == 0) prog_i = ~prog_i;
            ldr_we_i = ($urandom % 6 == 0); ldr_addr_i = rand_addr(); ldr_wdata_i = $urandom;
            if (!if_hold) begin if_req_i = ($urandom % 3 != 0); if_addr_i = rand_addr(); end
            if (!bus_hold) begin
                bus_req_i = ($urandom % 3 != 0); bus_we_i = $urandom % 2; bus_be_i = 4'($urandom);
                bus_addr_i = rand_addr(); bus_wdata_i = $urandom;
            end
            look();
            n_cmp++;
            if ({if_gnt_o, bus_gnt_o, mem_csb_o, mem_web_o} !== {e_if_gnt, e_bus_gnt, e_csb, e_web}) begin
                n_bad++; $display("FAIL rand_ctrl c%0d: got gnt=%b%b csb=%b web=%b expected %b%b %b %b", c,
                    if_gnt_o, bus_gnt_o, mem_csb_o, mem_web_o, e_if_gnt, e_bus_gnt, e_csb, e_web);
            end
            n_cmp++;
            if ({mem_addr_o, mem_wdata_o} !== {e_addr, e_wdata} || (!e_web && mem_wmask_o !== e_wmask)) begin
                n_bad++; $display("FAIL rand_pins c%0d: got a=%h d=%h m=%h expected a=%h d=%h m=%h", c,
                    mem_addr_o, mem_wdata_o, mem_wmask_o, e_addr, e_wdata, e_wmask);
            end
            n_cmp++;
            if ({if_rvalid_o, bus_rvalid_o} !== {e_if_rv, e_bus_rv} ||
                (e_if_rv && if_rdata_o !== e_if_rd) || (e_bus_rv && bus_rdata_o !== e_bus_rd)) begin
                n_bad++; $display("FAIL rand_rsp c%0d: got rv=%b%b d=%h/%h expected rv=%b%b d=%h/%h", c,
                    if_rvalid_o, bus_rvalid_o, if_rdata_o, bus_rdata_o, e_if_rv, e_bus_rv, e_if_rd, e_bus_rd);
            end
            if_hold  = if_req_i && !e_if_gnt;
            bus_hold = bus_req_i && !e_bus_gnt;
            tick();
        end
        idle(); look(); tick();
    endtask

    initial begin
        idle();
        ldr_addr_i = 12'h0; ldr_wdata_i = 32'h0; if_addr_i = 12'h0;
        bus_addr_i = 12'h0; bus_wdata_i = 32'h0; bus_be_i = 4'h0;
        test_reset();
        test_loader_fill();
        test_fetch_read();
        test_contention();
        test_loader_override();
        test_bus_byte_write();
        test_prog_mode();
        test_reset_mid_response();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_iccm_port_arbiter
`default_nettype wire

// File: doc/iccm_port_arbiter.md
Name: iccm_port_arbiter

Overview:
Shares the single-port ICCM SRAM macro between three requesters: the UART program loader (write-only), the core instruction-fetch port, and the system-bus/debug port.
- Grants exactly one access per cycle and drives the SRAM control pins.
- Routes the 1-cycle-latency read data back to whichever requester issued the read.
- Sits between the loader, the core and the ICCM macro in the user-project wrapper.

Parameters:
ADDR_W, 12, word address width of ICCM
DATA_W, 32, data word width
BE_W, 4, byte-enable width (DATA_W/8)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
prog_i  in  1  programming mode; blocks fetch and bus access
ldr_we_i  in  1  loader write strobe (single-cycle pulse)
ldr_addr_i  in  ADDR_W  loader word address
ldr_wdata_i  in  DATA_W  loader write data
if_req_i  in  1  fetch read request
if_addr_i  in  ADDR_W  fetch word address
if_gnt_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  fetch read data valid
if_rdata_o  out  DATA_W  fetch read data
bus_req_i  in  1  bus request
bus_we_i  in  1  bus write (1) / read (0)
bus_be_i  in  BE_W  bus byte enables
bus_addr_i  in  ADDR_W  bus word address
bus_wdata_i  in  DATA_W  bus write data
bus_gnt_o  out  1  bus request accepted this cycle
bus_rvalid_o  out  1  bus response (read data, or write ack)
bus_rdata_o  out  DATA_W  bus read data
mem_csb_o  out  1  SRAM chip select, active-low
mem_web_o  out  1  SRAM write enable, active-low
mem_wmask_o  out  BE_W  SRAM byte write mask
mem_addr_o  out  ADDR_W  SRAM address
mem_wdata_o  out  DATA_W  SRAM write data
mem_rdata_i  in  DATA_W  SRAM read data, valid 1 cycle after read select

Behaviour:
Clock and reset
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset state: rr_ptr=IF, rsp_sel=NONE, if_rvalid_o=0, bus_rvalid_o=0, rdata outputs 0.
- While rst_i=1: all grants are 0, mem_csb_o=1, mem_web_o=1.

Arbitration (combinational, same cycle as request)
- Priority 1, loader: ldr_we_i=1 always wins and is never stalled.
  - SRAM: csb=0, web=0, wmask=4'hF.
  - if_gnt_o=0 and bus_gnt_o=0 that cycle; losing requesters hold their request.
- Priority 2, prog_i=1: if_gnt_o=0 and bus_gnt_o=0 regardless of requests.
- Otherwise if_req_i and bus_req_i are round-robin arbitrated on rr_ptr:
  - The requester rr_ptr points to wins a tie.
  - After any fetch/bus grant, rr_ptr moves to the other requester.
  - A lone request is granted immediately and rr_ptr still toggles.
- Bus write: csb=0, web=0, wmask=bus_be_i. Reads drive web=1 and wmask=0.
- No grant: csb=1, web=1; addr/wdata are don't-care and are driven 0.

Handshake
- Requester holds req/addr/data stable until it sees gnt=1.
- Granted transfer completes on that edge.

Response pipeline (registered, 1 cycle)
- rsp_sel <= {NONE, IF, BUS} as the granted reader/writer at each edge.
- rsp_sel=IF: if_rvalid_o=1 and if_rdata_o=mem_rdata_i, in the cycle after the grant.
- rsp_sel=BUS, read: bus_rvalid_o=1 and bus_rdata_o=mem_rdata_i.
- rsp_sel=BUS, write: bus_rvalid_o=1 and bus_rdata_o=0 (write ack).
- Loader writes produce no response.
- Back-to-back grants give one response per cycle, strictly in grant order.

Boundary conditions
- Address wrap: addresses are used unmodified, with no range check.
- prog_i rising while a response is pending: the pending response is still delivered next cycle.
- rst_i mid-response: the response is dropped and rvalid is 0 the following cycle.
- All three requesters active: loader wins. Fetch and bus resume round-robin on the first cycle ldr_we_i=0, and rr_ptr is unchanged by loader cycles.
- Continuous fetch and bus requests: strict alternation, max wait 1 grant slot plus loader cycles.

Decomposition:
- Package iccm_arb_pkg holds:
  - requester enum: REQ_NONE=0, REQ_LDR=1, REQ_IF=2, REQ_BUS=3.
  - ICCM_ADDR_W=12, ICCM_DATA_W=32, ICCM_BE_W=4.
- One sub-module, iccm_rr_arb2: 2-way round-robin with an enable input (low when the loader is active or prog_i=1). It outputs one-hot grants and owns rr_ptr.
- SRAM pin muxing and the response register stay in the top module.

Test Plan:
- Reset: hold rst_i=1 for 3 cycles with if_req_i=1 -> if_gnt_o=0, mem_csb_o=1, both rvalid=0. Release -> fetch granted, rr_ptr moves to BUS.
- Fetch read: if_req_i=1, if_addr_i=12'h010, SRAM word 0x00000013 -> same cycle mem_csb_o=0, mem_web_o=1, mem_addr_o=12'h010. Next cycle if_rvalid_o=1, if_rdata_o=0x00000013.
- Contention: if_req_i and bus_req_i held high for 4 cycles after reset -> grants IF, BUS, IF, BUS. Each response appears 1 cycle later on the matching port.
- Loader override: ldr_we_i=1, ldr_addr_i=12'h005, ldr_wdata_i=0xDEADBEEF with if_req_i=1 -> SRAM write, wmask=4'hF, if_gnt_o=0. Next cycle fetch granted, then read of 12'h005 returns 0xDEADBEEF.
- Bus byte write: bus_we_i=1, bus_be_i=4'b0011, bus_wdata_i=0x1234ABCD to 12'h020 -> mem_wmask_o=4'b0011, next cycle bus_rvalid_o=1 with rdata 0. Subsequent read returns 0x????ABCD with the upper bytes unchanged.
- prog_i=1 with if_req_i=1 and bus_req_i=1 for 5 cycles -> no fetch/bus grants, loader writes still accepted. After prog_i=0, fetch is granted the next cycle.
